// File: rtl/keypad_pkg.sv
// Shared types, 4x4 key-code map and code-to-value helper for the keypad scanner.
package keypad_pkg;

  // FSM states are plain constants so older tools that mishandle enums in
  // case items still elaborate the controller.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PRESSED = 2'd1;
  localparam state_t ST_LOCKED  = 2'd2;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } scan_res_e;

  localparam logic [3:0] BTN_1     = 4'd0;
  localparam logic [3:0] BTN_2     = 4'd1;
  localparam logic [3:0] BTN_3     = 4'd2;
  localparam logic [3:0] BTN_PLUS  = 4'd3;
  localparam logic [3:0] BTN_4     = 4'd4;
  localparam logic [3:0] BTN_5     = 4'd5;
  localparam logic [3:0] BTN_6     = 4'd6;
  localparam logic [3:0] BTN_MINUS = 4'd7;
  localparam logic [3:0] BTN_7     = 4'd8;
  localparam logic [3:0] BTN_8     = 4'd9;
  localparam logic [3:0] BTN_9     = 4'd10;
  localparam logic [3:0] BTN_EQ    = 4'd11;
  localparam logic [3:0] BTN_0     = 4'd13;

  // Digits map to 0-9, operators to A (+), B (-), C (=); unused positions give F.
  function automatic logic [3:0] code_to_value(input logic [3:0] code);
    case (code)
      BTN_0:     return 4'd0;
      BTN_1:     return 4'd1;
      BTN_2:     return 4'd2;
      BTN_3:     return 4'd3;
      BTN_4:     return 4'd4;
      BTN_5:     return 4'd5;
      BTN_6:     return 4'd6;
      BTN_7:     return 4'd7;
      BTN_8:     return 4'd8;
      BTN_9:     return 4'd9;
      BTN_PLUS:  return 4'hA;
      BTN_MINUS: return 4'hB;
      BTN_EQ:    return 4'hC;
      default:   return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/sync2.sv
// N-bit two-flop synchroniser for the asynchronous row sense inputs.
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot column drive, per-scan classification,
// multi-scan debounce and a single strobe per accepted press.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no key accepted; waiting for a stable single press
// ST_PRESSED | key accepted and still held; a stable release is required
// ST_LOCKED  | stable multi-key seen; ignore everything until stable release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int KEY_W          = $clog2(N_ROWS*N_COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] rows,
  output logic [N_COLS-1:0] cols,
  output logic [KEY_W-1:0]  key,
  output logic              key_valid,
  output logic              key_held
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(N_COLS - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);
  localparam logic [N_COLS-1:0] COL0     = N_COLS'(1);

  logic [N_ROWS-1:0] row_s;
  logic [DIV_W-1:0]  div_cnt;
  logic [COL_W-1:0]  col_idx;
  logic [1:0]        hit_cnt;
  logic [KEY_W-1:0]  hit_code;
  scan_res_e         prev_res;
  logic [KEY_W-1:0]  prev_code;
  logic [STAB_W-1:0] stab_cnt;
  state_t            state;

  logic              tc;
  logic              scan_end;
  logic [1:0]        col_hits;
  logic [KEY_W-1:0]  col_code;
  logic [2:0]        hit_sum;
  logic [1:0]        scan_hits;
  logic [KEY_W-1:0]  scan_code;
  scan_res_e         scan_res;
  logic              same_res;
  logic [STAB_W-1:0] stab_nxt;
  logic              stable;
  state_t            state_nxt;
  logic              accept;

  sync2 #(.W(N_ROWS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rows),
    .q   (row_s)
  );

  assign tc       = (div_cnt == DIV_LAST);
  assign scan_end = tc && (col_idx == COL_LAST);

  // Hits in the column being sampled now, saturating at two.
  always_comb begin
    col_hits = 2'd0;
    col_code = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (row_s[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_code = KEY_W'(r * N_COLS + int'(col_idx));
      end
    end
  end

  // Whole-scan view including the last column, used at scan_end.
  always_comb begin
    hit_sum   = {1'b0, hit_cnt} + {1'b0, col_hits};
    scan_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    scan_code = (col_hits != 2'd0) ? col_code : hit_code;
    case (scan_hits)
      2'd0:    scan_res = RES_NONE;
      2'd1:    scan_res = RES_SINGLE;
      default: scan_res = RES_MULTI;
    endcase
  end

  always_comb begin
    same_res = (scan_res == prev_res) &&
               ((scan_res != RES_SINGLE) || (scan_code == prev_code));
    if (!same_res)
      stab_nxt = STAB_W'(1);
    else if (stab_cnt == STAB_MAX)
      stab_nxt = stab_cnt;
    else
      stab_nxt = stab_cnt + STAB_W'(1);
    stable = (stab_nxt == STAB_MAX);
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    if (scan_end && stable) begin
      case (state)
        ST_IDLE: begin
          if (scan_res == RES_SINGLE) begin
            state_nxt = ST_PRESSED;
            accept    = 1'b1;
          end else if (scan_res == RES_MULTI) begin
            state_nxt = ST_LOCKED;
          end
        end
        ST_PRESSED: begin
          if (scan_res == RES_NONE)       state_nxt = ST_IDLE;
          else if (scan_res == RES_MULTI) state_nxt = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (scan_res == RES_NONE) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      col_idx   <= '0;
      cols      <= COL0;
      hit_cnt   <= 2'd0;
      hit_code  <= '0;
      prev_res  <= RES_NONE;
      prev_code <= '0;
      stab_cnt  <= '0;
      state     <= ST_IDLE;
      key       <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      key_valid <= accept;
      key_held  <= (state_nxt == ST_PRESSED);
      if (accept) key <= scan_code;

      if (tc) begin
        div_cnt <= '0;
        cols    <= {cols[N_COLS-2:0], cols[N_COLS-1]};
        if (scan_end) begin
          col_idx   <= '0;
          hit_cnt   <= 2'd0;
          hit_code  <= '0;
          prev_res  <= scan_res;
          prev_code <= scan_code;
          stab_cnt  <= stab_nxt;
        end else begin
          col_idx <= col_idx + COL_W'(1);
          hit_cnt <= scan_hits;
          if (col_hits != 2'd0) hit_code <= col_code;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Parametrised matrix-keypad scanner and successor to the combinational keypad decoder.
- Drives the columns one-hot and samples the rows through a synchroniser.
- Classifies each full scan as none, single or multi, debounces over several consecutive scans, and emits one strobe per debounced press.
- Sits between the keypad pins and the calculator control logic. It outputs a raw key code, and a package table maps codes to digit and operator values.

Parameters:
- N_ROWS, 4, number of row sense inputs.
- N_COLS, 4, number of column drive outputs.
- SCAN_DIV, 1000, clock cycles each column is driven. Must be ≥ 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan results required before acting. Must be ≥ 1.
- KEY_W, $clog2(N_ROWS*N_COLS), key code width.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- rows, input, N_ROWS, raw row sense. Active-high when a key in the driven column is pressed. Asynchronous to clk.
- cols, output, N_COLS, one-hot column drive, active-high.
- key, output, KEY_W, code of the last accepted key: row*N_COLS + col.
- key_valid, output, 1, one-cycle strobe when key is updated.
- key_held, output, 1, high while the accepted key remains debounced-pressed.

Behaviour:
- Reset: one clock, synchronous active-high; every flop updates only on clk.
  - While rst is high at a clk edge: cols=1 (col 0), key=0, key_valid=0, key_held=0.
  - Divider, column index, scan accumulators and stability counter are cleared; the synchroniser flops are set to 0; FSM goes to IDLE.
  - Reset mid-scan discards the partial scan and any debounce progress.
- Synchroniser: rows pass through 2 flops; these registered outputs are the synchronised rows (row_s).
- Divider: counts 0..SCAN_DIV-1.
  - At terminal count, row_s is sampled for the current column.
  - On that same edge cols rotates left one bit; bit N_COLS-1 wraps to bit 0.
  - Sampling at end of dwell absorbs the synchroniser latency.
- Scan accumulation: per sampled column, add popcount(row_s) to hit_cnt (saturate at 2). For each set bit, record code = r*N_COLS + c.
- End of scan (sample of column N_COLS-1): result is NONE (hit_cnt=0), SINGLE(code) (=1) or MULTI (≥2). Accumulators then clear for the next scan.
- Debounce:
  - If result equals prev_result (code included for SINGLE), stab_cnt increments, saturating at DEBOUNCE_SCANS. Otherwise stab_cnt=1.
  - prev_result is updated every scan.
  - A result is "stable" on the scan where stab_cnt reaches DEBOUNCE_SCANS, and on every later scan while unchanged.
- FSM, evaluated only at end of scan with a stable result:
  - IDLE + SINGLE(c) → PRESSED. key<=c and key_valid=1 for exactly one cycle.
  - IDLE + MULTI → LOCKED. No strobe.
  - PRESSED + NONE → IDLE.
  - PRESSED + SINGLE(other code) → stay in PRESSED. No strobe: a release is required between accepted keys.
  - PRESSED + MULTI → LOCKED.
  - LOCKED + NONE → IDLE. Any other result stays in LOCKED.
  - An unstable result never changes state.
- key holds its last value in all states. key_held = (state==PRESSED), registered.
- Latency: a clean press present for a whole scan gives key_valid at the end of the DEBOUNCE_SCANS-th full scan. That is at most (DEBOUNCE_SCANS+1)·N_COLS·SCAN_DIV cycles after the press.
- Widths: divider $clog2(SCAN_DIV), column index $clog2(N_COLS), stab_cnt $clog2(DEBOUNCE_SCANS+1).

Decomposition:
- Package keypad_pkg holds:
  - state enum IDLE/PRESSED/LOCKED;
  - scan-result enum NONE/SINGLE/MULTI;
  - 4x4 code constants: BTN_1=0, BTN_2=1, BTN_3=2, BTN_PLUS=3, BTN_4=4, BTN_5=5, BTN_6=6, BTN_MINUS=7, BTN_7=8, BTN_8=9, BTN_9=10, BTN_EQ=11, BTN_0=13;
  - function code_to_value returning digit 0-9 and hex A/B/C.
- One sub-module, sync2: an N-bit 2-flop synchroniser with synchronous reset.

Test Plan:
All scenarios use N_ROWS=N_COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=3 (scan period 16 cycles).
- Reset/scan: rst 2 cycles then release → cols=0001, key=0, key_valid=0, key_held=0. cols steps 0010/0100/1000 every 4 cycles and returns to 0001 at cycle 16.
- Clean press: rows[1] high whenever cols[2] is driven, held for 200 cycles → exactly one key_valid pulse with key=6, within 64 cycles of press. key_held=1 until 3 NONE scans after release, then 0. key stays 6.
- Bounce: toggle that key every 10 cycles for 150 cycles, then hold it → no pulse during bouncing, then exactly one pulse with key=6.
- Multi-key: codes 5 and 6 both pressed → no pulse, key_held=0. Release one → still no pulse. Release both, then press 0 → one pulse, key=0.
- Repeat/rollover: press 6, release, press 6 → two pulses. Press 6, then roll to 9 without a stable NONE in between → no second pulse.
- Reset mid-press: rst pulsed while key 6 is held and key_held=1 → outputs return to reset values. After release of rst, one new pulse with key=6 after debounce.
